// File: rtl/instr_mem_pipe.sv
// Instruction memory with a one-entry registered fetch response.
// On reset the whole array is overwritten with FILL, one word per cycle.
// After that the block serves fetches with 1-cycle latency and accepts
// program-load writes. Bad fetch addresses return FILL with a fault flag.
// Bad write addresses are dropped without a fault.
module instr_mem_pipe #(
    parameter int                DATA_W = 32,
    parameter int                DEPTH  = 64,
    parameter int                ADDR_W = 32,
    parameter logic [DATA_W-1:0] FILL   = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    // fetch request
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    // fetch response
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_fault,
    // program load
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    // status
    output logic              busy
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);

    // One past the last legal byte address. It is one bit wider than the
    // address so the bound is representable even when it equals 2**ADDR_W.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH * BYTES);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_init_cnt;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_resp_fault;

    logic              w_req_ok;
    logic [IDX_W-1:0]  w_req_idx;
    logic              w_wr_ok;
    logic [IDX_W-1:0]  w_wr_idx;
    logic              w_req_ready;
    logic              w_accept;
    logic [DATA_W-1:0] w_rd_word;

    logic              w_mem_we;
    logic [IDX_W-1:0]  w_mem_idx;
    logic [DATA_W-1:0] w_mem_wdata;

    // An address is usable when it is word aligned and below the array size.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a[OFF-1:0] == '0) && ({1'b0, a} < LIMIT);
    endfunction

    // Address decode for the fetch port and the load port.
    always_comb begin
        w_req_ok  = addr_ok(req_addr);
        w_req_idx = req_addr[OFF+IDX_W-1:OFF];
        w_wr_ok   = addr_ok(wr_addr);
        w_wr_idx  = wr_addr[OFF+IDX_W-1:OFF];
    end

    // Fetch handshake. The output register can take a new word when it is
    // empty or is being drained in this same cycle.
    always_comb begin
        w_req_ready = (r_state == ST_RUN) && (!r_resp_valid || resp_ready);
        w_accept    = req_valid && w_req_ready;
        w_rd_word   = r_mem[w_req_idx];
    end

    // FSM state register and init counter.
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values, regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + IDX_W'(1);
            end
        end
    end

    // FSM next state: leave INIT on the same edge that fills the last word.
    // NOTE: the default assignment comes first, so no path through this
    // block leaves the target unassigned. That prevents an inferred latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: begin
                if (r_init_cnt == IDX_W'(DEPTH - 1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Single write port: the init fill owns it in INIT. After that, any
    // aligned, in-range load write uses it, whatever the fetch handshake state.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_idx   = w_wr_idx;
        w_mem_wdata = wr_data;
        if (r_state == ST_INIT) begin
            w_mem_we    = 1'b1;
            w_mem_idx   = r_init_cnt;
            w_mem_wdata = FILL;
        end else if (wr_en && w_wr_ok) begin
            w_mem_we = 1'b1;
        end
    end

    // Memory array write. A fetch on the same edge reads the pre-edge
    // contents, which gives read-before-write on a collision.
    // NOTE: the array is deliberately not on reset_n. The INIT fill
    // rewrites every word after each reset, so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_wdata;
        end
    end

    // Output register: load on accept, clear when drained, hold while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_fault <= 1'b0;
        end else if (w_accept) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_req_ok ? w_rd_word : FILL;
            r_resp_fault <= !w_req_ok;
        end else if (resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    // Output drive.
    always_comb begin
        req_ready  = w_req_ready;
        resp_valid = r_resp_valid;
        resp_data  = r_resp_data;
        resp_fault = r_resp_fault;
        busy       = (r_state == ST_INIT);
    end

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Self-checking bench for instr_mem_pipe. It has two parts: a table of
// loads and fetches, and hand-written sequences for stall, collision and
// mid-run reset. Expected fetch results go into a queue when a request is
// issued. A negedge monitor pops and compares them when a response drains.
module tb_instr_mem_pipe;

    localparam int          DATA_W = 32;
    localparam int          DEPTH  = 64;
    localparam int          ADDR_W = 32;
    localparam logic [31:0] FILL   = 32'h0000_0013;

    logic              clk;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_fault;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;

    instr_mem_pipe #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .FILL   (FILL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_fault (resp_fault),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        fault;
    } exp_t;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        bit          exp_fault;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[18];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a fetch. Wait (bounded) for req_ready, record the expectation
    // and cross the accepting edge. req_valid stays high for back-to-back use.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input bit f);
        int n;
        exp_t e;
        req_valid = 1'b1;
        req_addr  = a;
        #1;
        n = 0;
        while (!req_ready && n < 50) begin
            n++;
            step();
            #1;
        end
        if (n >= 50) check("req_ready_timeout", 64'd0, 64'd1);
        e.data  = d;
        e.fault = f;
        exp_q.push_back(e);
        step();
    endtask

    // Count the cycles busy stays high after reset release (bounded).
    task automatic wait_init(input string name);
        int cnt;
        cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            step();
        end
        check(name, 64'(cnt), 64'd64);
    endtask

    // Scoreboard monitor: a response drains on the coming edge.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_resp", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_resp_data", 64'(resp_data), 64'(e.data));
                check("sb_resp_fault", 64'(resp_fault), 64'(e.fault));
            end
        end
    end

    // Global time limit.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            is_wr  addr           wdata          exp_data       exp_fault
        vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,         FILL,          1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0000, 32'h2002_0005, 32'h0,         1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0004, 32'h2003_000C, 32'h0,         1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0102, 32'hBADB_AD00, 32'h0,         1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0003, 32'h1111_1111, 32'h0,         1'b0};
        vecs[5]  = '{1'b1, 32'h0000_0008, 32'hAAAA_0000, 32'h0,         1'b0};
        vecs[6]  = '{1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 32'h0,         1'b0};
        vecs[7]  = '{1'b1, 32'h0000_0100, 32'h1234_5678, 32'h0,         1'b0};
        vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h2002_0005, 1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0004, 32'h0,         32'h2003_000C, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_0002, 32'h0,         FILL,          1'b1};
        vecs[11] = '{1'b0, 32'h0000_0100, 32'h0,         FILL,          1'b1};
        vecs[12] = '{1'b0, 32'h0000_00FC, 32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[13] = '{1'b0, 32'h0000_0008, 32'h0,         32'hAAAA_0000, 1'b0};
        vecs[14] = '{1'b0, 32'h0000_0010, 32'h0,         FILL,          1'b0};
        vecs[15] = '{1'b0, 32'h0000_00F8, 32'h0,         FILL,          1'b0};
        vecs[16] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         FILL,          1'b1};
        vecs[17] = '{1'b0, 32'h0000_0104, 32'h0,         FILL,          1'b1};

        // Reset, with a load write held on through INIT that must be ignored.
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        resp_ready = 1'b1;
        wr_en      = 1'b1;
        wr_addr    = 32'h0000_0010;
        wr_data    = 32'hDEAD_BEEF;
        step();
        step();
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data", 64'(resp_data), 64'd0);
        check("rst_resp_fault", 64'(resp_fault), 64'd0);

        reset_n = 1'b1;
        wait_init("init_busy_cycles");
        wr_en = 1'b0;
        #1;
        check("run_req_ready", 64'(req_ready), 64'd1);
        check("run_busy", 64'(busy), 64'd0);

        // Table: loads are single-cycle writes; fetches go back to back.
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].is_wr) begin
                req_valid = 1'b0;
                wr_en     = 1'b1;
                wr_addr   = vecs[i].addr;
                wr_data   = vecs[i].wdata;
                step();
                wr_en = 1'b0;
            end else begin
                issue(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_fault);
                check($sformatf("vec%0d_resp_valid", i), 64'(resp_valid), 64'd1);
            end
        end
        req_valid = 1'b0;
        step();
        step();
        check("drain_resp_valid_low", 64'(resp_valid), 64'd0);

        // Stall: response held 3 cycles with a new request pending, and a
        // load write during the stall.
        resp_ready = 1'b0;
        issue(32'h0000_0000, 32'h2002_0005, 1'b0);
        req_addr = 32'h0000_0004;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                wr_en   = 1'b1;
                wr_addr = 32'h0000_00FC;
                wr_data = 32'h0BAD_C0DE;
            end
            #1;
            check($sformatf("stall%0d_req_ready", i), 64'(req_ready), 64'd0);
            check($sformatf("stall%0d_resp_valid", i), 64'(resp_valid), 64'd1);
            check($sformatf("stall%0d_resp_data", i), 64'(resp_data), 64'h2002_0005);
            check($sformatf("stall%0d_resp_fault", i), 64'(resp_fault), 64'd0);
            step();
            wr_en = 1'b0;
        end
        resp_ready = 1'b1;
        #1;
        check("unstall_req_ready", 64'(req_ready), 64'd1);
        begin
            exp_t e;
            e.data  = 32'h2003_000C;
            e.fault = 1'b0;
            exp_q.push_back(e);
        end
        step();
        check("unstall_resp_valid", 64'(resp_valid), 64'd1);
        req_valid = 1'b0;
        step();

        // Collision: fetch and write of word 0x8 on the same edge.
        wr_en   = 1'b1;
        wr_addr = 32'h0000_0008;
        wr_data = 32'h5555_FFFF;
        issue(32'h0000_0008, 32'hAAAA_0000, 1'b0);
        wr_en = 1'b0;
        issue(32'h0000_0008, 32'h5555_FFFF, 1'b0);
        issue(32'h0000_00FC, 32'h0BAD_C0DE, 1'b0);
        req_valid = 1'b0;
        step();
        step();

        // Mid-run reset during a stalled response.
        resp_ready = 1'b0;
        issue(32'h0000_0000, 32'h2002_0005, 1'b0);
        req_valid = 1'b0;
        check("pre_reset_resp_valid", 64'(resp_valid), 64'd1);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_resp_valid", 64'(resp_valid), 64'd0);
        check("arst_resp_data", 64'(resp_data), 64'd0);
        check("arst_req_ready", 64'(req_ready), 64'd0);
        check("arst_busy", 64'(busy), 64'd1);
        resp_ready = 1'b1;
        step();
        reset_n = 1'b1;
        wait_init("reinit_busy_cycles");
        issue(32'h0000_0000, FILL, 1'b0);
        issue(32'h0000_0004, FILL, 1'b0);
        issue(32'h0000_0008, FILL, 1'b0);
        req_valid = 1'b0;
        step();
        step();
        step();
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
